// File: rtl/dram16_fifo_ctrl_pkg.sv
// Shared definitions for the 16-entry DRAM16XN FIFO controller.
// Holds the storage depth, pointer/level widths, the pointer type and the
// pointer-advance helper used by the controller.
package dram16_fifo_ctrl_pkg;

    localparam int DEPTH   = 16;   // RAM entries
    localparam int ADDR_W  = 4;    // RAM address width
    localparam int PTR_W   = 5;    // wrap bit + 4-bit address
    localparam int LEVEL_W = 5;    // total words held, 0..17

    typedef logic [PTR_W-1:0] ptr_t;

    // Advance a pointer by one; the 5-bit width makes it wrap 31 -> 0.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1'b1);
    endfunction

endpackage

// File: rtl/dram16_fifo_ctrl_ram.sv
// DRAM16XN-style distributed RAM: 16 words, synchronous write, asynchronous
// dual-port read. Contents are not reset.
// Ports:
//   clk        write clock
//   we         write enable (one word per rising edge)
//   addr       write address
//   addr_dp    read address of the dual port
//   din        write word
//   dpo        asynchronous read word at addr_dp
// The single-port read output of the primitive is not brought out because
// the controller never reads through the write port.
module dram16_fifo_ctrl_ram
    import dram16_fifo_ctrl_pkg::*;
#(
    parameter int data_width = 20
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [ADDR_W-1:0]     addr_dp,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] dpo
);

    logic [data_width-1:0] mem_r [DEPTH];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
    end

    assign dpo = mem_r[addr_dp];

endmodule

// File: rtl/dram16_fifo_ctrl.sv
// 16-entry FIFO controller around a DRAM16XN distributed RAM with a
// registered output stage, used between the DVI pixel pipeline and the
// TMDS encoder feed.
// Ports:
//   CLK           clock, all state on the rising edge
//   RST           asynchronous active-high reset
//   FLUSH         synchronous clear of pointers and output stage
//   WR_DATA       write word
//   WR_VALID      producer offers WR_DATA
//   WR_READY      controller accepts (RAM not full and no FLUSH)
//   RD_DATA       registered head word
//   RD_VALID      RD_DATA holds a valid word
//   RD_READY      consumer takes RD_DATA
//   LEVEL         RAM occupancy + output stage (0..17), registered
//   ALMOST_FULL   RAM occupancy >= AF_LEVEL, registered
//   ALMOST_EMPTY  LEVEL <= AE_LEVEL, registered
module dram16_fifo_ctrl
    import dram16_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [LEVEL_W-1:0]    LEVEL,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY
);

    localparam ptr_t                AF_C = ptr_t'(AF_LEVEL);
    localparam logic [LEVEL_W-1:0]  AE_C = LEVEL_W'(AE_LEVEL);

    ptr_t                  wr_ptr_r;
    ptr_t                  rd_ptr_r;
    logic                  rd_valid_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic [LEVEL_W-1:0]    level_r;
    logic                  af_r;
    logic                  ae_r;

    ptr_t                  ram_cnt_s;
    logic                  ram_full_s;
    logic                  ram_empty_s;
    logic                  wr_ready_s;
    logic                  wr_xfer_s;
    logic                  rd_xfer_s;
    logic                  load_s;
    logic [DATA_WIDTH-1:0] dpo_s;

    ptr_t                  wr_ptr_nxt_s;
    ptr_t                  rd_ptr_nxt_s;
    logic                  rd_valid_nxt_s;
    logic [DATA_WIDTH-1:0] rd_data_nxt_s;
    ptr_t                  ram_cnt_nxt_s;
    logic [LEVEL_W-1:0]    level_nxt_s;
    logic                  af_nxt_s;
    logic                  ae_nxt_s;

    // Occupancy is the modulo-32 pointer difference; the wrap bit makes 16 distinct from 0.
    assign ram_cnt_s   = wr_ptr_r - rd_ptr_r;
    assign ram_full_s  = (ram_cnt_s == ptr_t'(DEPTH));
    assign ram_empty_s = (ram_cnt_s == ptr_t'(1'b0));

    // Ready depends only on registered state and FLUSH, never on RD_READY.
    assign wr_ready_s = !ram_full_s && !FLUSH;
    assign wr_xfer_s  = WR_VALID && wr_ready_s;
    assign rd_xfer_s  = rd_valid_r && RD_READY;
    // A load needs a RAM word, so the read address never equals a live write address.
    assign load_s     = !ram_empty_s && (!rd_valid_r || RD_READY);

    dram16_fifo_ctrl_ram #(
        .data_width (DATA_WIDTH)
    ) u_ram (
        .clk     (CLK),
        .we      (wr_xfer_s),
        .addr    (wr_ptr_r[ADDR_W-1:0]),
        .addr_dp (rd_ptr_r[ADDR_W-1:0]),
        .din     (WR_DATA),
        .dpo     (dpo_s)
    );

    // Next pointers, output stage and flags; FLUSH overrides every transfer.
    always_comb begin
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        rd_valid_nxt_s = rd_valid_r;
        rd_data_nxt_s  = rd_data_r;
        if (FLUSH) begin
            wr_ptr_nxt_s   = ptr_t'(1'b0);
            rd_ptr_nxt_s   = ptr_t'(1'b0);
            rd_valid_nxt_s = 1'b0;
        end else begin
            if (wr_xfer_s) begin
                wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (load_s) begin
                rd_ptr_nxt_s   = ptr_inc(rd_ptr_r);
                rd_valid_nxt_s = 1'b1;
                rd_data_nxt_s  = dpo_s;
            end else if (rd_xfer_s) begin
                // Drain with nothing behind it: data is held, only valid drops.
                rd_valid_nxt_s = 1'b0;
            end else begin
                rd_valid_nxt_s = rd_valid_r;
            end
        end
        ram_cnt_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
        level_nxt_s   = ram_cnt_nxt_s + LEVEL_W'(rd_valid_nxt_s);
        af_nxt_s      = (ram_cnt_nxt_s >= AF_C);
        ae_nxt_s      = (level_nxt_s <= AE_C);
    end

    // Controller state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r   <= ptr_t'(1'b0);
            rd_ptr_r   <= ptr_t'(1'b0);
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DATA_WIDTH{1'b0}};
            level_r    <= {LEVEL_W{1'b0}};
            af_r       <= 1'b0;
            ae_r       <= 1'b1;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            rd_valid_r <= rd_valid_nxt_s;
            rd_data_r  <= rd_data_nxt_s;
            level_r    <= level_nxt_s;
            af_r       <= af_nxt_s;
            ae_r       <= ae_nxt_s;
        end
    end

    assign WR_READY     = wr_ready_s;
    assign RD_DATA      = rd_data_r;
    assign RD_VALID     = rd_valid_r;
    assign LEVEL        = level_r;
    assign ALMOST_FULL  = af_r;
    assign ALMOST_EMPTY = ae_r;

endmodule

// File: tb/tb_dram16_fifo_ctrl.sv
// Self-checking bench for dram16_fifo_ctrl: a directed vector table, hand
// sequences for fill/full/flush/async reset, and randomized traffic checked
// against a queue-based model of the FIFO.
module tb_dram16_fifo_ctrl;

    localparam int DW = 20;

    logic          CLK = 1'b0;
    logic          RST;
    logic          FLUSH;
    logic [DW-1:0] WR_DATA;
    logic          WR_VALID;
    logic          WR_READY;
    logic [DW-1:0] RD_DATA;
    logic          RD_VALID;
    logic          RD_READY;
    logic [4:0]    LEVEL;
    logic          ALMOST_FULL;
    logic          ALMOST_EMPTY;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words in the RAM plus the output register.
    logic [DW-1:0] m_ram[$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          wrdy_seen;
    int            accepted;

    typedef struct {
        logic          fl;
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        logic          e_wrdy;
        logic          e_rv;
        logic          chk_d;
        logic [DW-1:0] e_d;
        logic [4:0]    e_lvl;
        logic          e_af;
        logic          e_ae;
    } vec_t;

    vec_t vecs[10];

    dram16_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .AF_LEVEL   (12),
        .AE_LEVEL   (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .FLUSH        (FLUSH),
        .WR_DATA      (WR_DATA),
        .WR_VALID     (WR_VALID),
        .WR_READY     (WR_READY),
        .RD_DATA      (RD_DATA),
        .RD_VALID     (RD_VALID),
        .RD_READY     (RD_READY),
        .LEVEL        (LEVEL),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ram.delete();
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    // Called at a negedge: drive inputs, check ready, advance model over the edge, check outputs.
    task automatic step(input logic fl, input logic wv, input logic [DW-1:0] wd, input logic rr);
        logic exp_wrdy;
        logic wr_x;
        logic rd_x;
        logic ld;
        int   lvl;
        FLUSH = fl; WR_VALID = wv; WR_DATA = wd; RD_READY = rr;
        #1;
        exp_wrdy  = (m_ram.size() < 16) && !fl;
        wrdy_seen = WR_READY;
        check("wr_ready", {31'd0, WR_READY}, {31'd0, exp_wrdy});
        wr_x = wv && exp_wrdy;
        rd_x = m_valid && rr;
        ld   = (m_ram.size() > 0) && (!m_valid || rr);
        @(posedge CLK);
        if (fl) begin
            m_ram.delete();
            m_valid = 1'b0;
        end else begin
            if (ld) begin
                m_data  = m_ram.pop_front();
                m_valid = 1'b1;
            end else if (rd_x) begin
                m_valid = 1'b0;
            end
            if (wr_x) m_ram.push_back(wd);
        end
        @(negedge CLK);
        lvl = m_ram.size() + int'(m_valid);
        check("rd_valid", {31'd0, RD_VALID}, {31'd0, m_valid});
        if (m_valid) check("rd_data", {12'd0, RD_DATA}, {12'd0, m_data});
        check("level", {27'd0, LEVEL}, lvl);
        check("almost_full", {31'd0, ALMOST_FULL}, {31'd0, (m_ram.size() >= 12)});
        check("almost_empty", {31'd0, ALMOST_EMPTY}, {31'd0, (lvl <= 2)});
    endtask

    task automatic do_reset();
        RST = 1'b1; FLUSH = 1'b0; WR_VALID = 1'b0; WR_DATA = '0; RD_READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_rd_valid", {31'd0, RD_VALID}, 32'd0);
        check("rst_rd_data", {12'd0, RD_DATA}, 32'd0);
        check("rst_level", {27'd0, LEVEL}, 32'd0);
        check("rst_af", {31'd0, ALMOST_FULL}, 32'd0);
        check("rst_ae", {31'd0, ALMOST_EMPTY}, 32'd1);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // fl, wv, wd, rr | wr_ready, rd_valid, chk_data, rd_data, level, af, ae
        vecs[0] = '{1'b0, 1'b1, 20'h00001, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00000, 5'd1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 20'h00002, 1'b0, 1'b1, 1'b1, 1'b1, 20'h00001, 5'd2, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 20'h00003, 1'b0, 1'b1, 1'b1, 1'b1, 20'h00001, 5'd3, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b1, 1'b1, 1'b1, 20'h00002, 5'd2, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 20'h00004, 1'b1, 1'b1, 1'b1, 1'b1, 20'h00003, 5'd2, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b1, 1'b1, 1'b1, 20'h00004, 5'd1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b1, 1'b0, 1'b1, 20'h00004, 5'd0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 20'h00005, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 5'd0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 20'h00006, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00000, 5'd1, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 20'h00000, 1'b0, 1'b1, 1'b1, 1'b1, 20'h00006, 5'd1, 1'b0, 1'b1};

        do_reset();

        // Directed table: latency, ordering, drain, flush dropping a write.
        for (int i = 0; i < 10; i++) begin
            FLUSH = vecs[i].fl; WR_VALID = vecs[i].wv; WR_DATA = vecs[i].wd; RD_READY = vecs[i].rr;
            #1;
            check($sformatf("vec%0d_wr_ready", i), {31'd0, WR_READY}, {31'd0, vecs[i].e_wrdy});
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("vec%0d_rd_valid", i), {31'd0, RD_VALID}, {31'd0, vecs[i].e_rv});
            if (vecs[i].chk_d) check($sformatf("vec%0d_rd_data", i), {12'd0, RD_DATA}, {12'd0, vecs[i].e_d});
            check($sformatf("vec%0d_level", i), {27'd0, LEVEL}, {27'd0, vecs[i].e_lvl});
            check($sformatf("vec%0d_af", i), {31'd0, ALMOST_FULL}, {31'd0, vecs[i].e_af});
            check($sformatf("vec%0d_ae", i), {31'd0, ALMOST_EMPTY}, {31'd0, vecs[i].e_ae});
        end

        do_reset();

        // Fill with RD_READY low: 17 words fit, then WR_READY drops.
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 20'h00100 + DW'(i), 1'b0);
            if (wrdy_seen) accepted++;
        end
        check("fill_accepted", accepted, 32'd17);
        check("fill_level", {27'd0, LEVEL}, 32'd17);
        check("fill_wr_ready", {31'd0, WR_READY}, 32'd0);
        check("fill_af", {31'd0, ALMOST_FULL}, 32'd1);

        // Single read from full: head advances to the second word, ready returns.
        step(1'b0, 1'b0, '0, 1'b1);
        check("full_pop_data", {12'd0, RD_DATA}, 32'h00101);
        check("full_pop_level", {27'd0, LEVEL}, 32'd16);
        RD_READY = 1'b0; WR_VALID = 1'b0;
        #1;
        check("full_pop_wr_ready", {31'd0, WR_READY}, 32'd1);
        for (int i = 0; i < 18; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Streaming: one word in and out per cycle, pointers wrap several times.
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 20'h20000 + DW'(i), 1'b1);

        // Flush at LEVEL 9 with a write offered: the write is dropped.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 20'h30000 + DW'(i), 1'b0);
        check("pre_flush_level", {27'd0, LEVEL}, 32'd9);
        step(1'b1, 1'b1, 20'h3FFFF, 1'b0);
        check("flush_level", {27'd0, LEVEL}, 32'd0);
        check("flush_rd_valid", {31'd0, RD_VALID}, 32'd0);
        step(1'b0, 1'b1, 20'hABCDE, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        check("post_flush_first", {12'd0, RD_DATA}, 32'hABCDE);
        step(1'b0, 1'b0, '0, 1'b1);

        // Async reset between edges mid-stream.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 20'h40000 + DW'(i), 1'b1);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_rd_valid", {31'd0, RD_VALID}, 32'd0);
        check("async_rst_rd_data", {12'd0, RD_DATA}, 32'd0);
        check("async_rst_level", {27'd0, LEVEL}, 32'd0);
        check("async_rst_ae", {31'd0, ALMOST_EMPTY}, 32'd1);
        WR_VALID = 1'b0; RD_READY = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        step(1'b0, 1'b1, 20'h5A5A5, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        check("rst_roundtrip", {12'd0, RD_DATA}, 32'h5A5A5);
        step(1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic: a write-heavy phase then a read-heavy phase.
        for (int i = 0; i < 400; i++) begin
            logic fl;
            logic wv;
            logic rr;
            fl = ($urandom_range(0, 47) == 0);
            if (i < 200) begin
                wv = ($urandom_range(0, 3) != 0);
                rr = ($urandom_range(0, 3) == 0);
            end else begin
                wv = ($urandom_range(0, 3) == 0);
                rr = ($urandom_range(0, 3) != 0);
            end
            step(fl, wv, DW'($urandom), rr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
